poly_envelope_mixer: RTL and testbench
======================================

# poly_envelope_mixer

Polyphonic successor to the single-voice synth path. It takes N_VOICES 8-bit oscillator samples, one per audio channel instance, each with its own gate. Each voice gets a linear attack/sustain/release envelope, and the voices are summed by a time-multiplexed shared multiplier. The output is a 16-bit left-aligned mix at a fixed sample rate. It sits between the per-voice audio channels / melody sequencers and the top-level `sound` output.

## Interface
- CLK_MHZ, 50, system clock frequency in MHz
- SAMPLE_KHZ, 48, output sample rate in kHz
  - TICK_DIV = CLK_MHZ*1000/SAMPLE_KHZ (integer division); must be ≥ N_VOICES+3
- N_VOICES, 4, voice count, range 1..256
  - W_ACC = 8+$clog2(N_VOICES), minimum 8
- clk_i  in  1  system clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- gate_i  in  N_VOICES  per-voice note-on level
- sample_i  in  N_VOICES×8  unsigned per-voice oscillator sample
- attack_step_i  in  8  level increment per tick in ATTACK (shared)
- release_step_i  in  8  level decrement per tick in RELEASE (shared)
- sample_tick_o  out  1  one-cycle strobe, once per TICK_DIV cycles
- active_o  out  N_VOICES  voice state ≠ IDLE
- mix_o  out  16  mixed sample: acc << (16−W_ACC)
- mix_valid_o  out  1  one-cycle strobe, mix_o updated

## Operation
**Tick counter**
- Counts 0..TICK_DIV−1, then wraps.
- sample_tick_o = (count == TICK_DIV−1).

**Per-voice envelope**
- 8-bit level; states IDLE, ATTACK, SUSTAIN, RELEASE.
- Updates only on tick cycles, using gate_i as sampled in that cycle.
- IDLE: gate=1 → ATTACK, and level += attack_step in the same update.
- ATTACK:
  - gate=0 → RELEASE, level unchanged this tick.
  - Otherwise level = min(level+attack_step, 255).
  - Reaching 255 → SUSTAIN in the same update.
  - attack_step=0 holds the level, stays in ATTACK.
- SUSTAIN: level held at 255; gate=0 → RELEASE.
- RELEASE:
  - gate=1 → ATTACK (retrigger from the current level, step applied).
  - Otherwise level = max(level−release_step, 0).
  - Reaching 0 → IDLE in the same update.
- Gate changes between ticks are invisible; pulses shorter than TICK_DIV cycles may be missed.

**Mixer**
- At the tick edge: snapshot all sample_i, clear the accumulator.
- Cycle T+1+k: acc += (snap[k] * level[k]) >> 8, where level[k] is the post-update level.
- No overflow is possible: acc max is N_VOICES*254 < 2^W_ACC.

## Timing
- Reset values:
  - count 0; all levels 0; all states IDLE.
  - sample_tick_o, active_o, mix_o, mix_valid_o all 0.
- First sample_tick_o occurs TICK_DIV−1 cycles after rst_i deasserts; after that, period is TICK_DIV.
- Latency: tick in cycle T → mix_o and mix_valid_o visible in cycle T+N_VOICES+1.
  - mix_valid_o is high exactly one cycle.
  - mix_o holds its value until the next valid.
- active_o changes in cycle T+1 after the envelope update.
- rst_i mid-accumulation: the partial sum is discarded, no mix_valid_o for that tick, all state returns to reset values on the next cycle.
- A tick coinciding with a gate edge: the gate value in the tick cycle is used.

## Structure
- Package poly_synth_pkg holds:
  - env_state_t enum (IDLE, ATTACK, SUSTAIN, RELEASE)
  - LEVEL_MAX = 8'd255
  - function w_acc(n)
- Sub-module voice_envelope, one instance per voice:
  - ports: clk_i, rst_i, tick_i, gate_i, attack_step_i, release_step_i, level_o, active_o
- Top level contains the tick counter, sample snapshot, voice sequencer counter, shared multiplier and accumulator.

## Test plan
Bench parameters: CLK_MHZ=1, SAMPLE_KHZ=100 (TICK_DIV=10), N_VOICES=4 (W_ACC=10, shift 6).
1. Reset release → all outputs 0; sample_tick_o at cycles 9, 19, 29; mix_valid_o 5 cycles after each tick; mix_o=0.
2. gate[0]=1, attack_step=64, sample[0]=200, others 0 → levels 64, 128, 192, 255 (SUSTAIN on tick 4); mix_o 3200, 6400, 9600, 12736.
3. From SUSTAIN, gate[0]=0, release_step=100 → levels 155, 55, 0; active_o[0] drops after the third tick; mix_o reaches 0.
4. All gates in SUSTAIN, all samples 255 → acc=1016, mix_o=65024, no wrap.
5. RELEASE at level 155, gate[0] reasserted with attack_step=64 → levels 219 then 255, state SUSTAIN; active_o[0] stays 1 throughout.
6. rst_i pulsed at T+2 during accumulation → no mix_valid_o for that tick; next cycle all outputs 0; next tick at 9 cycles after reset release.

Source files
------------

// File: rtl/poly_synth_pkg.sv
// ============================================================================
// poly_synth_pkg : shared types and helpers for the polyphonic envelope mixer
// Rev 1.0
// ============================================================================
`default_nettype none

package poly_synth_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ATTACK  = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } env_state_t;

  localparam logic [7:0] LEVEL_MAX = 8'd255;

  // Accumulator width: 8-bit scaled products summed over n voices.
  function automatic int w_acc(input int n);
    return (n > 1) ? 8 + $clog2(n) : 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/voice_envelope.sv
// ============================================================================
// voice_envelope : linear attack/sustain/release level for one voice
// Rev 1.0
// ============================================================================
`default_nettype none

module voice_envelope
  import poly_synth_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       gate_i,
  input  logic [7:0] attack_step_i,
  input  logic [7:0] release_step_i,
  output logic [7:0] level_o,
  output logic       active_o
);

  env_state_t r_state;
  logic [7:0] r_level;
  logic       r_active;
  logic [8:0] w_up_sum;
  logic [7:0] w_up_sat;
  logic [7:0] w_down_sat;

  assign w_up_sum   = {1'b0, r_level} + {1'b0, attack_step_i};
  assign w_up_sat   = w_up_sum[8] ? LEVEL_MAX : w_up_sum[7:0];
  assign w_down_sat = (r_level > release_step_i) ? (r_level - release_step_i) : 8'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_level  <= 8'd0;
      r_active <= 1'b0;
    end else if (tick_i) begin
      case (r_state)
        IDLE: begin
          if (gate_i) begin
            r_state  <= ATTACK;
            r_level  <= w_up_sat;
            r_active <= 1'b1;
          end
        end
        ATTACK: begin
          if (!gate_i) begin
            r_state <= RELEASE;
          end else begin
            r_level <= w_up_sat;
            if (w_up_sat == LEVEL_MAX) r_state <= SUSTAIN;
          end
        end
        SUSTAIN: begin
          r_level <= LEVEL_MAX;
          if (!gate_i) r_state <= RELEASE;
        end
        RELEASE: begin
          if (gate_i) begin
            // Retrigger climbs from wherever the release had reached.
            r_state <= ATTACK;
            r_level <= w_up_sat;
          end else begin
            r_level <= w_down_sat;
            if (w_down_sat == 8'd0) begin
              r_state  <= IDLE;
              r_active <= 1'b0;
            end
          end
        end
        default: begin
          r_state  <= IDLE;
          r_level  <= 8'd0;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign level_o  = r_level;
  assign active_o = r_active;

endmodule

`default_nettype wire

// File: rtl/poly_envelope_mixer.sv
// ============================================================================
// poly_envelope_mixer : N-voice enveloped mixer with one shared multiplier
// Rev 1.0
// ============================================================================
`default_nettype none

module poly_envelope_mixer
  import poly_synth_pkg::*;
#(
  parameter int CLK_MHZ    = 50,
  parameter int SAMPLE_KHZ = 48,
  parameter int N_VOICES   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N_VOICES-1:0]   gate_i,
  input  logic [N_VOICES*8-1:0] sample_i,
  input  logic [7:0]            attack_step_i,
  input  logic [7:0]            release_step_i,
  output logic                  sample_tick_o,
  output logic [N_VOICES-1:0]   active_o,
  output logic [15:0]           mix_o,
  output logic                  mix_valid_o
);

  localparam int TICK_DIV = CLK_MHZ * 1000 / SAMPLE_KHZ;
  localparam int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int W_ACC    = w_acc(N_VOICES);
  localparam int SHIFT    = 16 - W_ACC;
  localparam int IDX_W    = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

  logic [CNT_W-1:0] r_count;
  logic             w_tick;
  logic [7:0]       w_level [N_VOICES];
  logic [7:0]       r_snap  [N_VOICES];
  logic             r_busy;
  logic [IDX_W-1:0] r_idx;
  logic [W_ACC-1:0] r_acc;
  logic [15:0]      r_mix;
  logic             r_valid;
  logic [15:0]      w_full;
  logic [W_ACC-1:0] w_sum;

  assign w_tick = (r_count == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || w_tick) r_count <= '0;
    else                 r_count <= r_count + 1'b1;
  end

  generate
    for (genvar i = 0; i < N_VOICES; i++) begin : g_voice
      voice_envelope u_env (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .tick_i         (w_tick),
        .gate_i         (gate_i[i]),
        .attack_step_i  (attack_step_i),
        .release_step_i (release_step_i),
        .level_o        (w_level[i]),
        .active_o       (active_o[i])
      );
    end
  endgenerate

  // Shared multiplier walks the voices one per cycle after the tick.
  assign w_full = 16'(r_snap[r_idx]) * 16'(w_level[r_idx]);
  assign w_sum  = r_acc + W_ACC'(w_full[15:8]);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy  <= 1'b0;
      r_idx   <= '0;
      r_acc   <= '0;
      r_mix   <= 16'd0;
      r_valid <= 1'b0;
      for (int i = 0; i < N_VOICES; i++) r_snap[i] <= 8'd0;
    end else begin
      r_valid <= 1'b0;
      if (w_tick) begin
        r_busy <= 1'b1;
        r_idx  <= '0;
        r_acc  <= '0;
        for (int i = 0; i < N_VOICES; i++) r_snap[i] <= sample_i[i*8 +: 8];
      end else if (r_busy) begin
        r_acc <= w_sum;
        r_idx <= r_idx + 1'b1;
        if (r_idx == IDX_W'(N_VOICES - 1)) begin
          r_busy  <= 1'b0;
          r_mix   <= 16'(w_sum) << SHIFT;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign sample_tick_o = w_tick;
  assign mix_o         = r_mix;
  assign mix_valid_o   = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_poly_envelope_mixer.sv
// ============================================================================
// tb_poly_envelope_mixer : directed checks of envelope sequencing and mixing
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_poly_envelope_mixer;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  gate = '0;
  logic [N*8-1:0] sample = '0;
  logic [7:0]    attack_step = 8'd0;
  logic [7:0]    release_step = 8'd0;
  logic          sample_tick;
  logic [N-1:0]  active;
  logic [15:0]   mix;
  logic          mix_valid;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  poly_envelope_mixer #(.CLK_MHZ(1), .SAMPLE_KHZ(100), .N_VOICES(N)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .gate_i         (gate),
    .sample_i       (sample),
    .attack_step_i  (attack_step),
    .release_step_i (release_step),
    .sample_tick_o  (sample_tick),
    .active_o       (active),
    .mix_o          (mix),
    .mix_valid_o    (mix_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_tick && n < 40);
  endtask

  // Called in the tick cycle; ends at tick+6.
  task automatic check_mix(input string tag, input logic [15:0] exp_mix, input logic [N-1:0] exp_active);
    step();
    check({tag, "_active"}, 32'(active), 32'(exp_active));
    repeat (3) step();
    check({tag, "_valid_early"}, 32'(mix_valid), 32'd0);
    step();
    check({tag, "_valid"}, 32'(mix_valid), 32'd1);
    check({tag, "_mix"}, 32'(mix), 32'(exp_mix));
    step();
    check({tag, "_valid_pulse"}, 32'(mix_valid), 32'd0);
    check({tag, "_mix_hold"}, 32'(mix), 32'(exp_mix));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bit seen_valid;

    // 1. reset and tick cadence
    step();
    step();
    rst = 1'b0;
    check("rst_tick", 32'(sample_tick), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_mix", 32'(mix), 32'd0);
    check("rst_valid", 32'(mix_valid), 32'd0);
    wait_tick(n);
    check("first_tick_cycle", n, 9);
    check_mix("idle0", 16'd0, 4'h0);
    wait_tick(n);
    check("tick_period_a", n, 4);
    check_mix("idle1", 16'd0, 4'h0);
    wait_tick(n);
    check("tick_period_b", n, 4);
    check_mix("idle2", 16'd0, 4'h0);

    // 2. attack on voice 0: 64,128,192,255
    gate = 4'b0001;
    attack_step = 8'd64;
    sample = {8'd0, 8'd0, 8'd0, 8'd200};
    wait_tick(n); check_mix("att64", 16'd3200, 4'b0001);
    wait_tick(n); check_mix("att128", 16'd6400, 4'b0001);
    wait_tick(n); check_mix("att192", 16'd9600, 4'b0001);
    wait_tick(n); check_mix("att255", 16'd12736, 4'b0001);

    // 5. release to 155, then retrigger: 219, 255
    gate = 4'b0000;
    release_step = 8'd100;
    wait_tick(n); check_mix("rel_enter", 16'd12736, 4'b0001);
    wait_tick(n); check_mix("rel155", 16'd7744, 4'b0001);
    gate = 4'b0001;
    wait_tick(n); check_mix("retrig219", 16'd10944, 4'b0001);
    wait_tick(n); check_mix("retrig255", 16'd12736, 4'b0001);

    // 3. full release from sustain: 255,155,55,0
    gate = 4'b0000;
    wait_tick(n); check_mix("rel2_enter", 16'd12736, 4'b0001);
    wait_tick(n); check_mix("rel2_155", 16'd7744, 4'b0001);
    wait_tick(n); check_mix("rel2_55", 16'd2688, 4'b0001);
    wait_tick(n); check_mix("rel2_0", 16'd0, 4'b0000);

    // 4. all voices, distinct samples, then full-scale
    gate = 4'hF;
    attack_step = 8'd255;
    sample = {8'd40, 8'd30, 8'd20, 8'd10};
    wait_tick(n); check_mix("all_distinct", 16'd6144, 4'hF);
    sample = {4{8'd255}};
    wait_tick(n); check_mix("all_full", 16'd65024, 4'hF);

    // 6. reset during accumulation
    wait_tick(n);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_mix", 32'(mix), 32'd0);
    check("midrst_valid", 32'(mix_valid), 32'd0);
    check("midrst_active", 32'(active), 32'd0);
    check("midrst_tick", 32'(sample_tick), 32'd0);
    n = 0;
    seen_valid = 1'b0;
    do begin
      step();
      n++;
      seen_valid = seen_valid | mix_valid;
    end while (!sample_tick && n < 40);
    check("midrst_next_tick", n, 9);
    check("midrst_no_valid", 32'(seen_valid), 32'd0);
    check_mix("post_rst", 16'd65024, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
